// File: rtl/control_pipe_if.sv
// control_pipe_if: ID-stage inputs and staged control outputs of the control pipeline
interface control_pipe_if;
  logic [8:0] id_ctrl;
  logic [4:0] id_rs, id_rt, id_rd;
  logic ex_zero;
  logic ex_RegDst, ex_ALUSrc;
  logic [1:0] ex_ALUOp;
  logic mem_MemRead, mem_MemWrite, mem_Branch;
  logic wb_RegWrite, wb_MemtoReg;
  logic [4:0] wb_wreg;
  logic pc_write, ifid_write, ifid_flush, pcsrc;
  logic [15:0] stall_count, flush_count;
  modport master (
    output id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    input ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, mem_Branch,
    input wb_RegWrite, wb_MemtoReg, wb_wreg, pc_write, ifid_write, ifid_flush, pcsrc,
    input stall_count, flush_count
  );
  modport slave (
    input id_ctrl, id_rs, id_rt, id_rd, ex_zero,
    output ex_RegDst, ex_ALUSrc, ex_ALUOp, mem_MemRead, mem_MemWrite, mem_Branch,
    output wb_RegWrite, wb_MemtoReg, wb_wreg, pc_write, ifid_write, ifid_flush, pcsrc,
    output stall_count, flush_count
  );
endinterface

// File: rtl/control_pipe.sv
// control_pipe: ID/EX, EX/MEM, MEM/WB control registers with load-use stall and branch flush
module control_pipe (
  input logic clk,
  input logic rst,
  control_pipe_if.slave p
);
  logic [8:0] idex_ctrl_q, idex_ctrl_d;
  logic [4:0] idex_rt_q, idex_rt_d, idex_rd_q, idex_rd_d;
  logic [5:0] exmem_ctrl_q, exmem_ctrl_d;
  logic [4:0] exmem_wreg_q, exmem_wreg_d;
  logic [1:0] memwb_ctrl_q, memwb_ctrl_d;
  logic [4:0] memwb_wreg_q, memwb_wreg_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic hazard, stall, pcsrc;
  // hazard/flush decisions and next stage contents; EX/MEM packs {MemtoReg,RegWrite,MemRead,MemWrite,Branch,zero}
  always_comb begin
    hazard = idex_ctrl_q[4] && idex_rt_q != 5'd0 && (idex_rt_q == p.id_rs || idex_rt_q == p.id_rt);
    pcsrc = exmem_ctrl_q[1] & exmem_ctrl_q[0];
    stall = hazard & ~pcsrc;
    idex_ctrl_d = (stall || pcsrc) ? 9'd0 : p.id_ctrl;
    idex_rt_d = p.id_rt;
    idex_rd_d = p.id_rd;
    exmem_ctrl_d = pcsrc ? 6'd0 : {idex_ctrl_q[6:2], p.ex_zero};
    exmem_wreg_d = pcsrc ? 5'd0 : (idex_ctrl_q[8] ? idex_rd_q : idex_rt_q);
    memwb_ctrl_d = exmem_ctrl_q[5:4];
    memwb_wreg_d = exmem_wreg_q;
    stall_cnt_d = stall_cnt_q + {15'd0, stall && stall_cnt_q != 16'hFFFF};
    flush_cnt_d = flush_cnt_q + {15'd0, pcsrc && flush_cnt_q != 16'hFFFF};
  end
  // all stages advance every edge; reset clears everything including counters
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_ctrl_q <= '0;
      idex_rt_q <= '0;
      idex_rd_q <= '0;
      exmem_ctrl_q <= '0;
      exmem_wreg_q <= '0;
      memwb_ctrl_q <= '0;
      memwb_wreg_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_ctrl_q <= idex_ctrl_d;
      idex_rt_q <= idex_rt_d;
      idex_rd_q <= idex_rd_d;
      exmem_ctrl_q <= exmem_ctrl_d;
      exmem_wreg_q <= exmem_wreg_d;
      memwb_ctrl_q <= memwb_ctrl_d;
      memwb_wreg_q <= memwb_wreg_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign p.ex_RegDst = idex_ctrl_q[8];
  assign p.ex_ALUSrc = idex_ctrl_q[7];
  assign p.ex_ALUOp = idex_ctrl_q[1:0];
  assign p.mem_MemRead = exmem_ctrl_q[3];
  assign p.mem_MemWrite = exmem_ctrl_q[2];
  assign p.mem_Branch = exmem_ctrl_q[1];
  assign p.wb_MemtoReg = memwb_ctrl_q[1];
  assign p.wb_RegWrite = memwb_ctrl_q[0];
  assign p.wb_wreg = memwb_wreg_q;
  assign p.pc_write = ~stall;
  assign p.ifid_write = ~stall;
  assign p.ifid_flush = pcsrc;
  assign p.pcsrc = pcsrc;
  assign p.stall_count = stall_cnt_q;
  assign p.flush_count = flush_cnt_q;
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed scoreboard bench for control_pipe
module tb_control_pipe;
  localparam logic [8:0] NOP = 9'b000000000, RTYPE = 9'b100100010, LW = 9'b011110000;
  localparam logic [8:0] BEQ = 9'b000000101, SW = 9'b010001000;
  localparam int EXRD = 0, EXAS = 1, EXOP = 2, MMR = 3, MMW = 4, MBR = 5, WRW = 6, WMR = 7, WWR = 8;
  localparam int PCW = 9, IFW = 10, IFF = 11, PCS = 12, STC = 13, FLC = 14;
  typedef struct {
    string tag;
    int due;
    int sel;
    logic [15:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0, passed = 0, total = 0;
  exp_t sb[$];
  control_pipe_if bus ();
  control_pipe dut (.clk(clk), .rst(rst), .p(bus));
  always #5 clk = ~clk;
  function automatic logic [15:0] obs(int sel);
    case (sel)
      EXRD: return {15'd0, bus.ex_RegDst};
      EXAS: return {15'd0, bus.ex_ALUSrc};
      EXOP: return {14'd0, bus.ex_ALUOp};
      MMR: return {15'd0, bus.mem_MemRead};
      MMW: return {15'd0, bus.mem_MemWrite};
      MBR: return {15'd0, bus.mem_Branch};
      WRW: return {15'd0, bus.wb_RegWrite};
      WMR: return {15'd0, bus.wb_MemtoReg};
      WWR: return {11'd0, bus.wb_wreg};
      PCW: return {15'd0, bus.pc_write};
      IFW: return {15'd0, bus.ifid_write};
      IFF: return {15'd0, bus.ifid_flush};
      PCS: return {15'd0, bus.pcsrc};
      STC: return bus.stall_count;
      default: return bus.flush_count;
    endcase
  endfunction
  task automatic want(string tag, int sel, int dly, logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.due = cyc + dly;
    e.sel = sel;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic drain();
    exp_t keep[$];
    logic [15:0] o;
    foreach (sb[i]) begin
      if (sb[i].due != cyc) keep.push_back(sb[i]);
      else begin
        o = obs(sb[i].sel);
        total++;
        assert (o === sb[i].v) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", sb[i].tag, o, sb[i].v);
      end
    end
    sb = keep;
  endtask
  task automatic step();
    #1 drain();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask
  task automatic drv(logic [8:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd, logic z);
    bus.id_ctrl = c;
    bus.id_rs = rs;
    bus.id_rt = rt;
    bus.id_rd = rd;
    bus.ex_zero = z;
  endtask
  initial begin
    rst = 1'b1;
    drv(NOP, 0, 0, 0, 0);
    step();
    rst = 1'b0;
    want("rst_ex_regdst", EXRD, 0, 0);
    want("rst_ex_alusrc", EXAS, 0, 0);
    want("rst_ex_aluop", EXOP, 0, 0);
    want("rst_mem_memread", MMR, 0, 0);
    want("rst_mem_memwrite", MMW, 0, 0);
    want("rst_mem_branch", MBR, 0, 0);
    want("rst_wb_regwrite", WRW, 0, 0);
    want("rst_wb_memtoreg", WMR, 0, 0);
    want("rst_wb_wreg", WWR, 0, 0);
    want("rst_pc_write", PCW, 0, 1);
    want("rst_ifid_write", IFW, 0, 1);
    want("rst_pcsrc", PCS, 0, 0);
    want("rst_ifid_flush", IFF, 0, 0);
    want("rst_stall_count", STC, 0, 0);
    want("rst_flush_count", FLC, 0, 0);
    drv(RTYPE, 1, 2, 3, 0);
    want("rt_ex_regdst", EXRD, 1, 1);
    want("rt_ex_aluop", EXOP, 1, 2);
    want("rt_ex_alusrc", EXAS, 1, 0);
    want("rt_wb_regwrite", WRW, 3, 1);
    want("rt_wb_memtoreg", WMR, 3, 0);
    want("rt_wb_wreg", WWR, 3, 3);
    step();
    drv(NOP, 0, 0, 0, 0);
    repeat (3) step();
    drv(LW, 1, 5, 0, 0);
    want("lw_mem_memread", MMR, 2, 1);
    want("lw_wb_memtoreg", WMR, 3, 1);
    want("lw_wb_wreg", WWR, 3, 5);
    step();
    drv(RTYPE, 5, 6, 7, 0);
    want("lu_pc_write", PCW, 0, 0);
    want("lu_ifid_write", IFW, 0, 0);
    want("lu_bubble_regdst", EXRD, 1, 0);
    want("lu_bubble_aluop", EXOP, 1, 0);
    want("lu_bubble_memread", MMR, 2, 0);
    want("lu_stall_count", STC, 1, 1);
    step();
    want("lu_pc_write_resume", PCW, 0, 1);
    want("lu_consumer_regdst", EXRD, 1, 1);
    want("lu_consumer_wreg", WWR, 3, 7);
    step();
    drv(NOP, 0, 0, 0, 0);
    repeat (3) step();
    drv(LW, 1, 0, 0, 0);
    step();
    drv(RTYPE, 0, 0, 8, 0);
    want("r0_pc_write", PCW, 0, 1);
    want("r0_stall_count", STC, 1, 1);
    step();
    drv(NOP, 0, 0, 0, 0);
    repeat (2) step();
    drv(BEQ, 1, 2, 0, 0);
    step();
    drv(SW, 3, 4, 0, 1);
    want("br_mem_branch", MBR, 1, 1);
    want("br_pcsrc", PCS, 1, 1);
    want("br_ifid_flush", IFF, 1, 1);
    want("br_sw_alusrc", EXAS, 1, 1);
    want("br_pcsrc_clear", PCS, 2, 0);
    want("br_sw_memwrite", MMW, 2, 0);
    want("br_sw_memwrite_late", MMW, 3, 0);
    want("br_flush_count", FLC, 2, 1);
    want("br_stall_count", STC, 2, 1);
    step();
    drv(NOP, 0, 0, 0, 0);
    repeat (3) step();
    drv(BEQ, 1, 2, 0, 0);
    step();
    drv(LW, 1, 9, 0, 1);
    step();
    drv(RTYPE, 9, 1, 2, 0);
    want("hz_pc_write", PCW, 0, 1);
    want("hz_ifid_write", IFW, 0, 1);
    want("hz_pcsrc", PCS, 0, 1);
    want("hz_ex_regdst", EXRD, 1, 0);
    want("hz_stall_count", STC, 1, 1);
    want("hz_flush_count", FLC, 1, 2);
    step();
    drv(NOP, 0, 0, 0, 0);
    repeat (2) step();
    drv(LW, 1, 5, 0, 0);
    step();
    drv(RTYPE, 5, 6, 7, 0);
    rst = 1'b1;
    want("rs_stall_seen", PCW, 0, 0);
    want("rs_ex_regdst", EXRD, 1, 0);
    want("rs_ex_alusrc", EXAS, 1, 0);
    want("rs_mem_memread", MMR, 1, 0);
    want("rs_wb_regwrite", WRW, 1, 0);
    want("rs_wb_wreg", WWR, 1, 0);
    want("rs_stall_count", STC, 1, 0);
    want("rs_flush_count", FLC, 1, 0);
    step();
    rst = 1'b0;
    want("rs_pc_write_after", PCW, 0, 1);
    want("rs_pcsrc_after", PCS, 0, 0);
    step();
    drv(NOP, 0, 0, 0, 0);
    repeat (2) step();
    drv(LW, 1, 5, 0, 0);
    step();
    force dut.stall_cnt_q = 16'hFFFF;
    #1 release dut.stall_cnt_q;
    drv(RTYPE, 5, 6, 7, 0);
    want("sat_pc_write", PCW, 0, 0);
    want("sat_stall_count", STC, 1, 16'hFFFF);
    step();
    drv(NOP, 0, 0, 0, 0);
    step();
    #1 drain();
    foreach (sb[i]) begin
      total++;
      $error("FAIL %s never checked expected=%0h", sb[i].tag, sb[i].v);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
